data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 177 +++++++++++++++++
 tb/tb_data_cache.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache
module data_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWriteData,
  input  logic [3:0]  cpuByteEn,
  input  logic        cpuRead,
  input  logic        cpuWrite,
  input  logic        flush,
  output logic [31:0] cpuReadData,
  output logic        cpuStall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEn,
  input  logic        memAck,
  input  logic [31:0] memReadData
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_beat;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*WORDS_PER_LINE];
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;
  // The CPU keeps flush/store asserted until cpuStall drops, so remember that
  // the held request has already been serviced to avoid repeating it.
  logic             r_flush_done;
  logic             r_store_done;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_hit;
  logic [TAG_W-1:0] w_m_tag;
  logic [IDX_W-1:0] w_m_idx;
  logic [OFF_W-1:0] w_m_off;
  logic             w_m_hit;
  logic             w_idle;
  logic             w_flush_req;
  logic             w_store_req;
  logic             w_load_req;
  logic             w_stall;
  logic             w_read_hit;
  logic             w_unused;

  // CPU-side address fields and hit detection
  assign w_tag    = cpuAddr[31 -: TAG_W];
  assign w_idx    = cpuAddr[2+OFF_W +: IDX_W];
  assign w_off    = cpuAddr[2 +: OFF_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = ^cpuAddr[1:0];

  // Fields of the address currently presented to memory
  assign w_m_tag = r_mem_addr[31 -: TAG_W];
  assign w_m_idx = r_mem_addr[2+OFF_W +: IDX_W];
  assign w_m_off = r_mem_addr[2 +: OFF_W];
  assign w_m_hit = r_valid[w_m_idx] && (r_tag[w_m_idx] == w_m_tag);

  // A store with a coincident read is a store; flush outranks both
  assign w_idle      = (r_state == S_IDLE);
  assign w_flush_req = flush && !r_flush_done;
  assign w_store_req = cpuWrite && !r_store_done;
  assign w_load_req  = cpuRead && !cpuWrite;
  assign w_stall     = !reset && (!w_idle || w_flush_req || w_store_req || (w_load_req && !w_hit));
  assign w_read_hit  = !reset && w_idle && !w_flush_req && w_load_req && w_hit;

  assign cpuStall     = w_stall;
  assign cpuReadData  = w_read_hit ? r_data[{w_idx, w_off}] : 32'h0;
  assign memReq       = r_mem_req;
  assign memWe        = r_mem_we;
  assign memAddr      = r_mem_addr;
  assign memWriteData = r_mem_wdata;
  assign memByteEn    = r_mem_be;

  // Control FSM: state, valid bits, beat counter and registered memory outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_beat       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_be     <= 4'h0;
      r_flush_done <= 1'b0;
      r_store_done <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_flush_done <= 1'b0;
        r_store_done <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_flush_req) begin
            r_valid      <= '0;
            r_flush_done <= 1'b1;
          end else if (w_store_req) begin
            r_state     <= S_WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {cpuAddr[31:2], 2'b00};
            r_mem_wdata <= cpuWriteData;
            r_mem_be    <= cpuByteEn;
          end else if (w_load_req && !w_hit) begin
            r_state    <= S_REFILL;
            r_beat     <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {cpuAddr[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
            r_mem_be   <= 4'hF;
          end
        end
        S_REFILL: begin
          if (memAck) begin
            if (r_beat == LAST_BEAT) begin
              r_valid[w_m_idx] <= 1'b1;
              r_state          <= S_IDLE;
              r_beat           <= '0;
              r_mem_req        <= 1'b0;
              r_mem_addr       <= 32'h0;
              r_mem_be         <= 4'h0;
            end else begin
              r_beat                   <= r_beat + 1'b1;
              r_mem_addr[2 +: OFF_W]   <= r_beat + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (memAck) begin
            r_state      <= S_IDLE;
            r_store_done <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_be     <= 4'h0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays: refill beats, and byte-merge of write-through store hits
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && memAck) begin
      r_data[{w_m_idx, r_beat}] <= memReadData;
      if (r_beat == LAST_BEAT) begin
        r_tag[w_m_idx] <= w_m_tag;
      end
    end
    if (r_state == S_WRITE && memAck && w_m_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mem_be[b]) begin
          r_data[{w_m_idx, w_m_off}][8*b +: 8] <= r_mem_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - randomized and directed self-checking bench for data_cache
module tb_data_cache;
  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpuAddr, cpuWriteData, cpuReadData, memAddr, memWriteData, memReadData;
  logic [3:0]  cpuByteEn, memByteEn;
  logic        cpuRead, cpuWrite, flush, cpuStall, memReq, memWe, memAck;

  int total = 0;
  int bad   = 0;
  int refills = 0;
  int refills_before;
  logic [31:0] last_rdata;
  bit          ab;
  int          op;
  logic [31:0] a;
  logic [31:0] bases [4] = '{32'h100, 32'h200, 32'h140, 32'h1140};

  // Reference model: backing memory (word k holds k unless written) and the
  // line base address resident at each index.
  logic [31:0] mem      [int unsigned];
  logic [31:0] resident [int];

  data_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuWriteData(cpuWriteData),
    .cpuByteEn(cpuByteEn), .cpuRead(cpuRead), .cpuWrite(cpuWrite), .flush(flush),
    .cpuReadData(cpuReadData), .cpuStall(cpuStall), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWriteData(memWriteData), .memByteEn(memByteEn),
    .memAck(memAck), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    int unsigned w = addr >> 2;
    return mem.exists(w) ? mem[w] : w;
  endfunction

  task automatic mem_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] cur = mem_rd(addr);
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
    mem[addr >> 2] = cur;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_flush();
    int stalls = 0;
    bit done = 0;
    @(posedge clk); #1; flush = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!cpuStall) begin done = 1; break; end
      stalls++;
    end
    resident.delete();
    chk("flush_complete", 32'(done), 32'h1);
    chk("flush_stall", stalls, 1);
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic access(input bit fl, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input int abort_beats, output bit aborted);
    logic [31:0] base, rdata, p_addr, exp_addr;
    logic        p_we;
    logic [3:0]  p_be;
    int idx, stalls, beats, req_cyc, we_cyc, exp_stall, exp_beats;
    bit hit, stable, have_p, done;
    base = addr & ~32'(LINE_BYTES - 1);
    idx  = int'((addr / LINE_BYTES) % LINES);
    if (fl) resident.delete();
    hit = resident.exists(idx) ? (resident[idx] == base) : 1'b0;
    exp_stall = fl ? 1 : 0;
    if (wr) begin exp_stall += 1 + hold; exp_beats = 1; end
    else if (!hit) begin exp_stall += 1 + WPL * hold; exp_beats = WPL; end
    else exp_beats = 0;
    @(posedge clk); #1;
    cpuAddr = addr; cpuRead = !wr; cpuWrite = wr; cpuWriteData = wd; cpuByteEn = be; flush = fl;
    aborted = 0; stalls = 0; beats = 0; req_cyc = 0; we_cyc = 0; stable = 1; have_p = 0; done = 0;
    rdata = 32'hx; p_addr = 0; p_we = 0; p_be = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      memAck = 1'b0; memReadData = 32'h0;
      if (abort_beats != 0 && beats == abort_beats) begin aborted = 1; break; end
      if (!cpuStall) begin rdata = cpuReadData; done = 1; break; end
      stalls++;
      if (memReq) begin
        if (have_p && (memAddr !== p_addr || memWe !== p_we || memByteEn !== p_be)) stable = 0;
        have_p = 1; p_addr = memAddr; p_we = memWe; p_be = memByteEn;
        req_cyc++;
        if (memWe) we_cyc++;
        if (req_cyc == hold) begin
          exp_addr = wr ? {addr[31:2], 2'b00} : base + 32'(beats * 4);
          chk("mem_addr", memAddr, exp_addr);
          chk("mem_we", memWe, wr);
          if (wr) begin
            chk("mem_byte_en", memByteEn, be);
            chk("mem_wdata", memWriteData, wd);
            mem_wr(addr, wd, be);
          end else begin
            chk("mem_byte_en", memByteEn, 4'hF);
            memReadData = mem_rd(memAddr);
          end
          memAck = 1'b1; beats++; req_cyc = 0; have_p = 0;
        end
      end
    end
    if (aborted) return;
    chk("complete", 32'(done), 32'h1);
    chk("stall_cycles", stalls, exp_stall);
    chk("mem_beats", beats, exp_beats);
    chk("req_stable", 32'(stable), 32'h1);
    if (wr) chk("we_cycles", we_cyc, hold);
    chk("read_data", rdata, wr ? 32'h0 : mem_rd(addr));
    last_rdata = rdata;
    if (!wr && !hit) begin resident[idx] = base; refills++; end
    @(posedge clk); #1;
    cpuRead = 1'b0; cpuWrite = 1'b0; flush = 1'b0; memAck = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpuAddr = 32'h100; cpuWriteData = 0; cpuByteEn = 0;
    cpuRead = 1'b1; cpuWrite = 1'b0; flush = 1'b0; memAck = 1'b0; memReadData = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_memreq", memReq, 1'b0);
    chk("reset_memwe", memWe, 1'b0);
    chk("reset_stall", cpuStall, 1'b0);
    chk("reset_rdata", cpuReadData, 32'h0);
    @(posedge clk); #1; reset = 1'b0; cpuRead = 1'b0;
    @(negedge clk);
    chk("idle_memreq", memReq, 1'b0);
    chk("idle_memwe", memWe, 1'b0);
    chk("idle_byte_en", memByteEn, 4'h0);
    chk("idle_memaddr", memAddr, 32'h0);
    chk("idle_wdata", memWriteData, 32'h0);
    chk("idle_stall", cpuStall, 1'b0);

    // cold read refill, then zero-penalty hit
    access(0, 0, 32'h100, 0, 0, 1, 0, ab);
    chk("cold_read_value", last_rdata, 32'h40);
    access(0, 0, 32'h104, 0, 0, 1, 0, ab);
    chk("hit_read_value", last_rdata, 32'h41);

    // partial store hit with slow memory, then read the merged word
    access(0, 1, 32'h104, 32'hAABBCCDD, 4'b0011, 3, 0, ab);
    access(0, 0, 32'h104, 0, 0, 1, 0, ab);
    chk("merged_word", last_rdata, 32'h0000CCDD);

    // store miss does not allocate
    access(0, 1, 32'h800, 32'h12345678, 4'hF, 1, 0, ab);
    access(0, 0, 32'h800, 0, 0, 1, 0, ab);

    // flush then conflict eviction on one index
    refills_before = refills;
    do_flush();
    access(0, 0, 32'h100, 0, 0, 1, 0, ab);
    access(0, 0, 32'h100 + 32'(16 * LINES), 0, 0, 2, 0, ab);
    access(0, 0, 32'h100, 0, 0, 1, 0, ab);
    chk("conflict_refills", refills - refills_before, 3);

    // flush coincident with a read and with a store
    access(1, 0, 32'h108, 0, 0, 1, 0, ab);
    access(1, 1, 32'h108, 32'h55AA55AA, 4'b1100, 2, 0, ab);

    // reset in the middle of a refill, with a late ack afterwards
    access(0, 0, 32'h300, 0, 0, 1, 2, ab);
    chk("abort_reached", 32'(ab), 32'h1);
    reset = 1'b1; #1;
    chk("abort_memreq", memReq, 1'b0);
    chk("abort_memwe", memWe, 1'b0);
    chk("abort_stall", cpuStall, 1'b0);
    chk("abort_rdata", cpuReadData, 32'h0);
    resident.delete();
    @(posedge clk); #1; cpuRead = 1'b0; memAck = 1'b1; memReadData = 32'hDEADBEEF;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; memAck = 1'b0; memReadData = 32'h0;
    @(negedge clk);
    chk("late_ack_memreq", memReq, 1'b0);
    chk("late_ack_stall", cpuStall, 1'b0);
    access(0, 0, 32'h300, 0, 0, 1, 0, ab);
    access(0, 0, 32'h308, 0, 0, 1, 0, ab);

    // random mix against the model
    for (int n = 0; n < 50; n++) begin
      op = int'($urandom_range(0, 9));
      a  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, WPL - 1) * 4);
      if (op == 0) do_flush();
      else access(op == 1, op >= 7, a, $urandom, 4'($urandom_range(1, 15)),
                  int'($urandom_range(1, 3)), 0, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
